// File: rtl/video_timing_prom_seq.sv
// Purpose : horizontal/vertical video timing sequencer; addresses the 256x4 timing PROM and registers its decode.
// Latency : sync/blank/alpha/frame strobes lag hcount/vcount by 1 ck; the PROM address is combinational.
// Backpressure: none; pix_en freezes the counters, and the output stage re-registers every ck.
//
// Ports:
//   ck          system clock, rising edge
//   reset       asynchronous, active-high
//   pix_en      pixel clock enable; counters advance only when 1
//   prom_A      PROM address (two pixels per entry)
//   prom_CE1_b  PROM chip enable 1, active-low (held high in reset so the PROM tri-states)
//   prom_CE2_b  PROM chip enable 2, active-low
//   prom_O      registered PROM data: [0] hsync, [1] hblank, [2] alpha fetch slot, [3] reserved
//   hcount      current pixel column, 0..H_TOTAL-1 (H_TOTAL must not exceed 512)
//   vcount      current line, 0..V_TOTAL-1
//   hsync_b     horizontal sync, active-low
//   vsync_b     vertical sync, active-low
//   hblank      horizontal blank
//   vblank      vertical blank
//   alpha_fetch one-ck strobe per pixel in an alpha tile fetch slot
//   frame_start one-ck pulse after the counters wrap to (0,0)
module video_timing_prom_seq #(
   parameter int H_TOTAL      = 456,
   parameter int V_TOTAL      = 262,
   parameter int VBLANK_START = 240,
   parameter int VBLANK_END   = 0,
   parameter int VSYNC_START  = 244,
   parameter int VSYNC_END    = 247
) (
   input  logic       ck,
   input  logic       reset,
   input  logic       pix_en,
   output logic [7:0] prom_A,
   output logic       prom_CE1_b,
   output logic       prom_CE2_b,
   input  logic [3:0] prom_O,
   output logic [8:0] hcount,
   output logic [8:0] vcount,
   output logic       hsync_b,
   output logic       vsync_b,
   output logic       hblank,
   output logic       vblank,
   output logic       alpha_fetch,
   output logic       frame_start
);

   localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
   localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);
   localparam logic [8:0] VB_S   = 9'(VBLANK_START);
   localparam logic [8:0] VB_E   = 9'(VBLANK_END);
   localparam logic [8:0] VS_S   = 9'(VSYNC_START);
   localparam logic [8:0] VS_E   = 9'(VSYNC_END);

   // Half-open window [s, e). When s > e the window wraps through the
   // end of the frame back to line 0.
   function automatic logic in_window(input logic [8:0] v,
                                      input logic [8:0] s,
                                      input logic [8:0] e);
      if (s <= e)
         return (v >= s) && (v < e);
      else
         return (v >= s) || (v < e);
   endfunction

   logic [8:0] hnext;
   logic [8:0] vnext;
   logic       h_wrap;
   logic       v_wrap;
   logic       ce_b;
   logic [1:0] valid_sr;
   logic       pix_en_d;
   logic       vblank_dec;
   logic       vsync_dec;

   // Bit 3 of the PROM word is reserved.
   logic       unused_prom_bit;
   assign unused_prom_bit = prom_O[3];

   // ------------------------------------------------------------------
   // Counter next-state and PROM address
   // ------------------------------------------------------------------
   always_comb begin
      h_wrap = (hcount == H_LAST);
      v_wrap = (vcount == V_LAST);
      hnext  = h_wrap ? 9'd0 : hcount + 9'd1;
      vnext  = v_wrap ? 9'd0 : vcount + 9'd1;
   end

   // The PROM registers its output on the same edge that moves hcount, so
   // it is given the post-edge column; its output then always matches the
   // column currently held in hcount.
   assign prom_A = pix_en ? hnext[8:1] : hcount[8:1];

   assign prom_CE1_b = ce_b;
   assign prom_CE2_b = ce_b;

   // ------------------------------------------------------------------
   // Vertical decode (parameter compares, no PROM involvement)
   // ------------------------------------------------------------------
   always_comb begin
      vblank_dec = in_window(vcount, VB_S, VB_E);
      vsync_dec  = in_window(vcount, VS_S, VS_E);
   end

   // ------------------------------------------------------------------
   // Counters
   // ------------------------------------------------------------------
   always_ff @(posedge ck or posedge reset) begin
      if (reset) begin
         hcount <= 9'd0;
         vcount <= 9'd0;
      end else if (pix_en) begin
         hcount <= hnext;
         if (h_wrap)
            vcount <= vnext;
      end
   end

   // ------------------------------------------------------------------
   // PROM enable and output-valid tracking
   // ------------------------------------------------------------------
   // The PROM is tri-stated in reset, so its first registered word after
   // release is garbage; valid_sr[1] marks the first trustworthy word.
   always_ff @(posedge ck or posedge reset) begin
      if (reset) begin
         ce_b     <= 1'b1;
         valid_sr <= 2'b00;
         pix_en_d <= 1'b0;
      end else begin
         ce_b     <= 1'b0;
         valid_sr <= {valid_sr[0], 1'b1};
         pix_en_d <= pix_en;
      end
   end

   // ------------------------------------------------------------------
   // Registered output stage (every ck, independent of pix_en)
   // ------------------------------------------------------------------
   always_ff @(posedge ck or posedge reset) begin
      if (reset) begin
         hsync_b     <= 1'b1;
         vsync_b     <= 1'b1;
         hblank      <= 1'b1;
         vblank      <= 1'b1;
         alpha_fetch <= 1'b0;
      end else if (!valid_sr[1]) begin
         hsync_b     <= 1'b1;
         vsync_b     <= 1'b1;
         hblank      <= 1'b1;
         vblank      <= 1'b1;
         alpha_fetch <= 1'b0;
      end else begin
         hsync_b     <= ~prom_O[0];
         hblank      <= prom_O[1];
         // prom_O stays on one entry while pix_en is low; qualifying with
         // the delayed enable fires the strobe once per pixel, not per ck.
         alpha_fetch <= prom_O[2] & pix_en_d;
         vblank      <= vblank_dec;
         vsync_b     <= ~vsync_dec;
      end
   end

   always_ff @(posedge ck or posedge reset) begin
      if (reset)
         frame_start <= 1'b0;
      else
         frame_start <= pix_en & h_wrap & v_wrap;
   end

endmodule

// File: tb/tb_video_timing_prom_seq.sv
module tb_video_timing_prom_seq;

   // Shortened frame so a full vertical wrap is reachable quickly;
   // horizontal timing keeps its production value.
   localparam int HT = 456;
   localparam int VT = 26;

   localparam int M_HC = 1;
   localparam int M_VC = 2;
   localparam int M_PA = 4;
   localparam int M_CE = 8;
   localparam int M_HS = 16;
   localparam int M_VS = 32;
   localparam int M_HB = 64;
   localparam int M_VB = 128;
   localparam int M_AF = 256;
   localparam int M_FS = 512;
   localparam int M_ALL = 1023;

   logic       ck = 1'b0;
   logic       reset = 1'b0;
   logic       pix_en = 1'b0;
   logic [7:0] prom_A;
   logic       prom_CE1_b, prom_CE2_b;
   logic [3:0] prom_O;
   logic [8:0] hcount, vcount;
   logic       hsync_b, vsync_b, hblank, vblank, alpha_fetch, frame_start;

   always #5 ck = ~ck;

   video_timing_prom_seq #(
      .H_TOTAL(HT), .V_TOTAL(VT),
      .VBLANK_START(20), .VBLANK_END(0),
      .VSYNC_START(22), .VSYNC_END(24)
   ) dut (
      .ck(ck), .reset(reset), .pix_en(pix_en),
      .prom_A(prom_A), .prom_CE1_b(prom_CE1_b), .prom_CE2_b(prom_CE2_b),
      .prom_O(prom_O),
      .hcount(hcount), .vcount(vcount),
      .hsync_b(hsync_b), .vsync_b(vsync_b),
      .hblank(hblank), .vblank(vblank),
      .alpha_fetch(alpha_fetch), .frame_start(frame_start)
   );

   // Registered 256x4 PROM; drives all-ones garbage while disabled.
   logic [3:0] mem [256];
   logic [3:0] prom_q = 4'hF;
   always @(posedge ck) begin
      if (!prom_CE1_b && !prom_CE2_b) prom_q <= mem[prom_A];
      else                            prom_q <= 4'hF;
   end
   assign prom_O = prom_q;

   typedef struct {
      int    cyc;
      string name;
      int    mask;
      int    hc, vc, pa, ce, hs, vs, hb, vb, af, fs;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc_cnt = 0;
   int   h_m = 0;
   int   v_m = 0;
   event probe;

   always @(posedge ck) cyc_cnt <= cyc_cnt + 1;

   task automatic chk(input string nm, input string fld, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s.%s: got %0d, expected %0d (t=%0t)", nm, fld, act, expv, $time);
      end
   endtask

   task automatic push_exp(input string nm, input int mask,
                           input int hc, input int vc, input int pa, input int ce,
                           input int hs, input int vs, input int hb, input int vb,
                           input int af, input int fs);
      exp_t e;
      e.cyc = cyc_cnt; e.name = nm; e.mask = mask;
      e.hc = hc; e.vc = vc; e.pa = pa; e.ce = ce;
      e.hs = hs; e.vs = vs; e.hb = hb; e.vb = vb; e.af = af; e.fs = fs;
      sb.push_back(e);
   endtask

   // Monitor: compares every expectation due by the current sample point.
   initial begin
      exp_t e;
      forever begin
         @(negedge ck or probe);
         while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
            e = sb.pop_front();
            if ((e.mask & M_HC) != 0) chk(e.name, "hcount", int'(hcount), e.hc);
            if ((e.mask & M_VC) != 0) chk(e.name, "vcount", int'(vcount), e.vc);
            if ((e.mask & M_PA) != 0) chk(e.name, "prom_A", int'(prom_A), e.pa);
            if ((e.mask & M_CE) != 0) begin
               chk(e.name, "prom_CE1_b", int'(prom_CE1_b), e.ce);
               chk(e.name, "prom_CE2_b", int'(prom_CE2_b), e.ce);
            end
            if ((e.mask & M_HS) != 0) chk(e.name, "hsync_b", int'(hsync_b), e.hs);
            if ((e.mask & M_VS) != 0) chk(e.name, "vsync_b", int'(vsync_b), e.vs);
            if ((e.mask & M_HB) != 0) chk(e.name, "hblank", int'(hblank), e.hb);
            if ((e.mask & M_VB) != 0) chk(e.name, "vblank", int'(vblank), e.vb);
            if ((e.mask & M_AF) != 0) chk(e.name, "alpha_fetch", int'(alpha_fetch), e.af);
            if ((e.mask & M_FS) != 0) chk(e.name, "frame_start", int'(frame_start), e.fs);
         end
      end
   end

   // One ck; tracks the expected raster position, then steps 1 unit past the edge.
   task automatic tick();
      @(posedge ck);
      if (reset) begin
         h_m = 0; v_m = 0;
      end else if (pix_en) begin
         if (h_m == HT - 1) begin
            h_m = 0;
            v_m = (v_m == VT - 1) ? 0 : v_m + 1;
         end else begin
            h_m++;
         end
      end
      #1;
   endtask

   task automatic run_to(input int h, input int v);
      int budget;
      budget = 30000;
      while (!(h_m == h && v_m == v) && budget > 0) begin
         tick();
         budget--;
      end
      if (!(h_m == h && v_m == v)) begin
         checks++;
         errors++;
         $display("FAIL run_to: position (%0d,%0d), required (%0d,%0d)", h_m, v_m, h, v);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 4'h0;
      mem[1]  = 4'b1101;   // hsync active, hblank off, alpha slot, reserved bit set
      mem[50] = 4'b0100;   // alpha slot only

      // ---- reset and release ----
      #1 reset = 1'b1;
      pix_en = 1'b1;
      repeat (3) tick();
      push_exp("rst_hold", M_ALL, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0);
      reset = 1'b0;
      tick(); push_exp("rel_e1", M_ALL, 1, 0, 1, 0, 1, 1, 1, 1, 0, 0);
      tick(); push_exp("rel_e2", M_ALL, 2, 0, 1, 0, 1, 1, 1, 1, 0, 0);
      tick(); push_exp("rel_e3", M_ALL, 3, 0, 2, 0, 0, 1, 0, 0, 1, 0);
      tick(); push_exp("rel_e4", M_ALL, 4, 0, 2, 0, 0, 1, 0, 0, 1, 0);
      tick(); push_exp("rel_e5", M_ALL, 5, 0, 3, 0, 1, 1, 0, 0, 0, 0);

      // ---- pix_en held low at hcount=100 ----
      run_to(100, 0);
      pix_en = 1'b0;
      push_exp("hold_in", M_HC|M_PA|M_HS|M_HB|M_AF, 100, 0, 50, 0, 1, 0, 0, 0, 0, 0);
      tick(); push_exp("hold_1", M_HC|M_PA|M_HS|M_HB|M_AF|M_FS, 100, 0, 50, 0, 1, 0, 0, 0, 1, 0);
      tick(); push_exp("hold_2", M_HC|M_PA|M_HS|M_HB|M_AF|M_FS, 100, 0, 50, 0, 1, 0, 0, 0, 0, 0);
      tick(); push_exp("hold_3", M_HC|M_PA|M_HS|M_HB|M_AF|M_FS, 100, 0, 50, 0, 1, 0, 0, 0, 0, 0);
      tick(); push_exp("hold_4", M_HC|M_PA|M_HS|M_HB|M_AF|M_FS, 100, 0, 50, 0, 1, 0, 0, 0, 0, 0);
      tick(); push_exp("hold_5", M_HC|M_PA|M_HS|M_HB|M_AF|M_FS, 100, 0, 50, 0, 1, 0, 0, 0, 0, 0);
      pix_en = 1'b1;
      tick(); push_exp("resume_1", M_HC|M_AF, 101, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick(); push_exp("resume_2", M_HC|M_AF, 102, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      tick(); push_exp("resume_3", M_HC|M_AF, 103, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // ---- PROM image: hsync+hblank on entries 200..210 only ----
      mem[1]  = 4'h0;
      mem[50] = 4'h0;
      for (int i = 200; i <= 210; i++) mem[i] = 4'b0011;
      run_to(396, 0);
      for (int i = 0; i < 32; i++) begin
         int in_win;
         if (i > 0) tick();
         in_win = (h_m >= 401 && h_m <= 422) ? 1 : 0;
         push_exp("hwin", M_HC|M_HS|M_HB, h_m, 0, 0, 0, 1 - in_win, 0, in_win, 0, 0, 0);
      end

      // ---- line wrap ----
      run_to(455, 10);
      push_exp("lw_pre", M_HC|M_VC|M_PA|M_FS, 455, 10, 0, 0, 0, 0, 0, 0, 0, 0);
      tick(); push_exp("lw_post", M_HC|M_VC|M_PA|M_FS, 0, 11, 0, 0, 0, 0, 0, 0, 0, 0);

      // ---- vertical windows ----
      run_to(0, 20);
      push_exp("vb_lag", M_VC|M_VB, 0, 20, 0, 0, 0, 0, 0, 0, 0, 0);
      tick(); push_exp("vb_on", M_VC|M_VB, 0, 20, 0, 0, 0, 0, 0, 1, 0, 0);
      run_to(0, 22);
      push_exp("vs_lag", M_VC|M_VS, 0, 22, 0, 0, 0, 1, 0, 0, 0, 0);
      tick(); push_exp("vs_on", M_VC|M_VS, 0, 22, 0, 0, 0, 0, 0, 0, 0, 0);
      run_to(0, 24);
      push_exp("vs_held", M_VC|M_VS, 0, 24, 0, 0, 0, 0, 0, 0, 0, 0);
      tick(); push_exp("vs_off", M_VC|M_VS|M_VB, 0, 24, 0, 0, 0, 1, 0, 1, 0, 0);

      // ---- frame wrap ----
      run_to(455, VT - 1);
      push_exp("fw_pre", M_HC|M_VC|M_FS|M_VB, 455, VT - 1, 0, 0, 0, 0, 0, 1, 0, 0);
      tick(); push_exp("fw_wrap", M_HC|M_VC|M_FS|M_VB, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
      tick(); push_exp("fw_next", M_HC|M_VC|M_FS|M_VB, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick(); push_exp("fw_after", M_HC|M_FS, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // ---- asynchronous reset mid-frame ----
      run_to(300, 12);
      push_exp("pre_rst", M_HC|M_VC|M_VB|M_CE, 300, 12, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge ck);
      #1 reset = 1'b1;
      push_exp("arst", M_ALL, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0);
      #1 -> probe;
      tick(); push_exp("arst_hold", M_HC|M_VC|M_CE|M_VB, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
      reset = 1'b0;
      tick(); push_exp("rr_e1", M_ALL, 1, 0, 1, 0, 1, 1, 1, 1, 0, 0);
      tick(); push_exp("rr_e2", M_ALL, 2, 0, 1, 0, 1, 1, 1, 1, 0, 0);
      tick(); push_exp("rr_e3", M_ALL, 3, 0, 2, 0, 1, 1, 0, 0, 0, 0);

      repeat (2) tick();
      if (sb.size() != 0) begin
         errors += sb.size();
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/video_timing_prom_seq.md
Name: video_timing_prom_seq

Overview:
- Horizontal/vertical video timing sequencer for the System 1 video path.
- Sits directly upstream of the 256x4 timing/decode PROM: drives its address and chip enables, and consumes its registered 4-bit output.
- Turns the PROM output into registered sync, blank and alpha-fetch strobes for the alpha and playfield stages.
- Vertical timing is parameter-compared, not PROM-driven.

Parameters:
- H_TOTAL, 456, pixels per line; hcount runs 0..H_TOTAL-1; must be ≤ 512.
- V_TOTAL, 262, lines per frame; vcount runs 0..V_TOTAL-1.
- VBLANK_START, 240, first vcount with vblank asserted.
- VBLANK_END, 0, first vcount with vblank deasserted; the vblank interval wraps through V_TOTAL-1 to 0.
- VSYNC_START, 244, first vcount with vsync active.
- VSYNC_END, 247, first vcount with vsync inactive.

Ports:
- ck, input, 1, system clock; everything is rising-edge.
- reset, input, 1, asynchronous, active-high.
- pix_en, input, 1, pixel clock enable; counters advance only when pix_en=1.
- prom_A, output, 8, PROM address.
- prom_CE1_b, output, 1, PROM chip enable 1, active-low.
- prom_CE2_b, output, 1, PROM chip enable 2, active-low.
- prom_O, input, 4, registered PROM data.
- hcount, output, 9, current pixel column.
- vcount, output, 9, current line.
- hsync_b, output, 1, horizontal sync, active-low.
- vsync_b, output, 1, vertical sync, active-low.
- hblank, output, 1, horizontal blank, active-high.
- vblank, output, 1, vertical blank, active-high.
- alpha_fetch, output, 1, one-ck strobe: alpha tile fetch slot.
- frame_start, output, 1, one-ck pulse when the counters wrap to (0,0).

Behaviour:
- Reset values, applied asynchronously while reset=1:
  - hcount=0, vcount=0.
  - hsync_b=1, vsync_b=1, hblank=1, vblank=1.
  - alpha_fetch=0, frame_start=0.
  - valid_sr=2'b00.
  - prom_CE1_b=prom_CE2_b=1, so the PROM tri-states.
- After reset deasserts, prom_CE1_b=prom_CE2_b=0 from the first ck edge onward.
- Counters: on an edge with pix_en=1:
  - hcount increments; at H_TOTAL-1 it wraps to 0.
  - On that wrap, vcount increments; at V_TOTAL-1 it wraps to 0.
  - pix_en=0 holds both counters.
- Address is combinational so the PROM samples the value the counter will hold after the edge:
  - prom_A = pix_en ? hnext[8:1] : hcount[8:1], where hnext is the post-increment/wrap value.
  - Consequently, after any edge, prom_O = mem[hcount[8:1]] for the current hcount (two pixels per PROM entry).
- PROM bit map: O[0]=hsync active, O[1]=hblank, O[2]=alpha fetch slot, O[3] reserved and ignored.
- Output stage, registered every ck (not gated by pix_en), so it lags hcount by exactly 1 ck:
  - hsync_b <= ~O[0]
  - hblank <= O[1]
  - alpha_fetch <= O[2] & pix_en_d, where pix_en_d is pix_en delayed 1 ck; this gives one strobe per pixel, never repeated during held cycles.
- Valid gating:
  - valid_sr shifts in 1 each ck after reset.
  - Until valid_sr[1]=1, the output stage loads its reset values regardless of prom_O, which may be Z/X.
  - PROM data is therefore trusted from the 2nd ck after reset release.
- Vertical decode, registered every ck from vcount with the same 1-ck lag:
  - vblank = in-window(vcount, VBLANK_START, VBLANK_END), wrap-aware.
  - vsync_b = ~in-window(vcount, VSYNC_START, VSYNC_END).
  - Both are also forced to reset values while valid_sr[1]=0.
- frame_start: registered; asserted for exactly 1 ck after the edge where (hcount,vcount) went (H_TOTAL-1, V_TOTAL-1) → (0,0) with pix_en=1.
- Boundaries:
  - pix_en held 0 for N cycles: all outputs are stable and no strobes fire.
  - Reset mid-line: counters return to 0 immediately, asynchronously, and the outputs re-enter the 2-ck invalid window.
  - H_TOTAL odd: the last PROM entry serves one pixel only; no special handling.

Test Plan:
1. Reset release with pix_en=1:
   - While reset=1, CE_b=1 and the outputs hold their reset values.
   - The first two edges after release keep the outputs at reset values.
   - At edge 3, hsync_b/hblank reflect mem[prom_A] sampled at edge 2.
2. Line wrap:
   - Drive to hcount=455, vcount=10 with pix_en=1.
   - Next edge: hcount=0, vcount=11, prom_A was 0 at that edge, and there is no frame_start.
3. Frame wrap:
   - hcount=455, vcount=261, pix_en=1.
   - Next edge: (0,0), and frame_start=1 for exactly 1 ck.
   - vblank deasserts 1 ck after vcount=0.
4. pix_en=0 for 5 cycles at hcount=100:
   - hcount stays 100 and prom_A stays 50.
   - alpha_fetch pulses at most once (at entry) and does not repeat.
   - The outputs do not change.
5. Load a PROM image with O=4'b0011 at entries 200..210 and 0 elsewhere:
   - hsync_b=0 and hblank=1 exactly for hcount 400..421, each delayed 1 ck.
6. Async reset asserted mid-frame (hcount=300, vcount=120):
   - Counters read 0 without a clock edge; CE_b=1.
   - vsync_b=1 and vblank=1 immediately.
